circuit_sweep_ctrl: RTL and testbench

//  - Sequencer for a 4-input combinational lab circuit: drives {A,B,C,D} through all 16 codes, 0..15.
//  - Samples the circuit's Y output for each code and compares it against an expected 16-bit truth table.
//  - Reports pass/fail, the mismatch count and the first failing code.
//  - Sits between the board-level start button/debouncer and the circuit under test (CUT); the CUT is external.

---
 rtl/sweep_pkg.sv | 23 ++
 rtl/settle_timer.sv | 43 ++++
 rtl/circuit_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_circuit_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_pkg
//  Purpose  : Shared types and sizes for the 4-input circuit sweep controller.
//  Revision : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    localparam int NUM_CODES = 16;
    localparam int CODE_W    = 4;
    localparam int CNT_W     = 5;

    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : settle_timer
//  Purpose  : Load/expire down-counter that sets how long each code settles.
//  Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    generate
        if (SETTLE_CYCLES == 0) begin : g_no_timer
            // The controller never enters SETTLE in this build.
            logic w_unused;
            assign w_unused = ^{clk, rst, load, en};
            assign expired  = 1'b1;
        end else begin : g_timer
            localparam logic [7:0] c_load = 8'(SETTLE_CYCLES - 1);

            logic [7:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 8'd0;
                end else if (load) begin
                    r_cnt <= c_load;
                end else if (en && (r_cnt != 8'd0)) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            assign expired = (r_cnt == 8'd0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/circuit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : circuit_sweep_ctrl
//  Purpose  : Steps an external 4-input circuit through all 16 codes, checks
//             Y against a golden truth table and reports the result.
//             SWEEP_CAPTURE_EN enables the observed-Y capture register.
//  Revision : 1.0 - initial release
// ============================================================================
module circuit_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int                   SETTLE_CYCLES = 2,
    parameter logic [NUM_CODES-1:0] EXPECTED      = 16'hF151
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 y_in,
    output logic [CODE_W-1:0]    abcd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CODE_W-1:0]    first_fail,
    output logic [NUM_CODES-1:0] captured
);

    localparam state_t c_code_entry = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t r_state;
    state_t w_next;

    logic              w_timer_load;
    logic              w_timer_en;
    logic              w_expired;
    logic              w_clear;
    logic              w_advance;
    logic              w_commit;
    logic              w_abort_clr;
    logic              w_mismatch;
    logic [CNT_W-1:0]  w_err_next;
    logic [CODE_W-1:0] w_first_next;

    logic [CODE_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_err_work;
    logic [CODE_W-1:0] r_first_work;
    logic              r_pass;
    logic [CNT_W-1:0]  r_err_count;
    logic [CODE_W-1:0] r_first_fail;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_timer_load),
        .en      (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_commit     = 1'b0;
        w_abort_clr  = abort && (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_clear      = 1'b1;
                    w_timer_load = 1'b1;
                    w_next       = c_code_entry;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_timer_en = 1'b1;
                    if (w_expired) begin
                        w_next = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (r_idx == LAST_CODE) begin
                    w_commit = 1'b1;
                    w_next   = DONE;
                end else begin
                    w_advance    = 1'b1;
                    w_timer_load = 1'b1;
                    w_next       = c_code_entry;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The final code's result is folded in combinationally so DONE sees it.
    assign w_mismatch   = (y_in != EXPECTED[r_idx]);
    assign w_err_next   = r_err_work + CNT_W'(w_mismatch);
    assign w_first_next = (w_mismatch && (r_err_work == '0)) ? r_idx : r_first_work;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_err_work   <= '0;
            r_first_work <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
        end else begin
            if (w_abort_clr) begin
                r_idx <= '0;
            end else if (w_clear) begin
                r_idx        <= '0;
                r_err_work   <= '0;
                r_first_work <= '0;
            end else if (r_state == SAMPLE) begin
                r_err_work   <= w_err_next;
                r_first_work <= w_first_next;
                if (w_advance) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_commit) begin
                r_pass       <= (w_err_next == '0);
                r_err_count  <= w_err_next;
                r_first_fail <= w_first_next;
            end
        end
    end

`ifdef SWEEP_CAPTURE_EN
    logic [NUM_CODES-1:0] r_cap_work;
    logic [NUM_CODES-1:0] r_captured;
    logic [NUM_CODES-1:0] w_cap_next;

    always_comb begin
        w_cap_next        = r_cap_work;
        w_cap_next[r_idx] = y_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_work <= '0;
            r_captured <= '0;
        end else begin
            if ((r_state == SAMPLE) && !abort) begin
                r_cap_work <= w_cap_next;
            end
            if (w_commit) begin
                r_captured <= w_cap_next;
            end
        end
    end

    assign captured = r_captured;
`else
    assign captured = '0;
`endif

    assign abcd       = r_idx;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_circuit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_circuit_sweep_ctrl
//  Purpose  : Scoreboard bench for circuit_sweep_ctrl (SETTLE_CYCLES 2 and 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_circuit_sweep_ctrl;

    localparam logic [15:0] c_exp = 16'hF151;

    typedef struct {
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  first;
        logic [15:0] cap;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, y_a;
    logic start_b = 1'b0, abort_b = 1'b0, y_b;
    logic [3:0]  abcd_a, abcd_b, first_a, first_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [4:0]  err_a, err_b;
    logic [15:0] cap_a, cap_b;

    int   mode_a = 0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    circuit_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(16'hF151)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .y_in(y_a),
        .abcd(abcd_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(first_a), .captured(cap_a)
    );

    circuit_sweep_ctrl #(.SETTLE_CYCLES(0), .EXPECTED(16'hF151)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .y_in(y_b),
        .abcd(abcd_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(first_b), .captured(cap_b)
    );

    // Model CUTs: 0 = golden, 1 = Y stuck at 0, 2 = golden with code 13 inverted.
    always_comb begin
        case (mode_a)
            1:       y_a = 1'b0;
            2:       y_a = c_exp[abcd_a] ^ (abcd_a == 4'd13);
            default: y_a = c_exp[abcd_a];
        endcase
        y_b = c_exp[abcd_b];
    end

    function automatic logic [15:0] cap_exp(input logic [15:0] v);
`ifdef SWEEP_CAPTURE_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_done_cycle", cyc, ea.cyc);
                chk("a_pass", pass_a, ea.pass);
                chk("a_err_count", err_a, ea.err);
                chk("a_first_fail", first_a, ea.first);
                chk("a_captured", cap_a, ea.cap);
            end
        end
        if (done_b) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_done_cycle", cyc, eb.cyc);
                chk("b_pass", pass_b, eb.pass);
                chk("b_err_count", err_b, eb.err);
                chk("b_first_fail", first_b, eb.first);
                chk("b_captured", cap_b, eb.cap);
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 200) begin
            step();
            n++;
        end
        chk("a_idle_timeout", busy_a, 1'b0);
    endtask

    task automatic run_a(input int m, input logic p, input logic [4:0] err,
                         input logic [3:0] first, input logic [15:0] cap);
        exp_t e;
        mode_a  = m;
        step();
        e.pass  = p;
        e.err   = err;
        e.first = first;
        e.cap   = cap_exp(cap);
        e.cyc   = cyc + 49;
        qa.push_back(e);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_idle_a();
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_abcd"}, abcd_a, 4'd0);
        chk({tag, "_busy"}, busy_a, 1'b0);
        chk({tag, "_done"}, done_a, 1'b0);
        chk({tag, "_pass"}, pass_a, 1'b0);
        chk({tag, "_err"}, err_a, 5'd0);
        chk({tag, "_first"}, first_a, 4'd0);
        chk({tag, "_captured"}, cap_a, 16'd0);
    endtask

    initial begin
        int k;
        int n;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_a("reset");
        chk("reset_b_busy", busy_b, 1'b0);
        rst = 1'b0;

        run_a(0, 1'b1, 5'd0, 4'h0, 16'hF151);
        run_a(1, 1'b0, 5'd8, 4'h0, 16'h0000);
        run_a(2, 1'b0, 5'd1, 4'hD, 16'hD151);

        // Abort 20 cycles into a sweep; results must stay from the last sweep.
        mode_a = 0;
        step();
        k = cyc;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (cyc < k + 20) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_abcd", abcd_a, 4'd0);
        repeat (60) step();
        chk("abort_pass", pass_a, 1'b0);
        chk("abort_err", err_a, 5'd1);
        chk("abort_first", first_a, 4'hD);
        chk("abort_captured", cap_a, cap_exp(16'hD151));

        // Asynchronous reset while code 7 is on the bus.
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (abcd_a != 4'd7 && n < 100) begin
            step();
            n++;
        end
        chk("rst_reach_code7", abcd_a, 4'd7);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_a("midrst");
        step();
        step();
        rst = 1'b0;
        run_a(0, 1'b1, 5'd0, 4'h0, 16'hF151);

        // Zero settle time with start held high: back-to-back 17-cycle sweeps.
        step();
        k = cyc;
        for (int j = 0; j < 6; j++) begin
            e.pass  = 1'b1;
            e.err   = 5'd0;
            e.first = 4'h0;
            e.cap   = cap_exp(16'hF151);
            e.cyc   = k + 17 + 18 * j;
            qb.push_back(e);
        end
        start_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("b_abcd_step%0d", i), abcd_b, i[3:0]);
        end
        while (cyc < k + 100) step();
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 100) begin
            step();
            n++;
        end
        chk("b_idle_timeout", busy_b, 1'b0);
        repeat (3) step();

        chk("a_pending_expect", qa.size(), 0);
        chk("b_pending_expect", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
